bram_port_ctrl: RTL and testbench
=================================

BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 1024, meaning the number of memory words on the attached port.
REQ-002 The block SHALL have parameter WIDTH, default 256, meaning the data width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports listed below.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both high (fire).
REQ-008 req_we  input  1  1 means write, 0 means read.
REQ-009 req_addr  input  $clog2(SIZE)  word address.
REQ-010 req_wdata  input  WIDTH  write data.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  response consumed when resp_valid and resp_ready are both high (pop).
REQ-013 resp_rdata  output  WIDTH  read-first data for the request.
REQ-014 bram_en, bram_we  output  1 each  drive the BRAM port enable and write enable.
REQ-015 bram_addr  output  $clog2(SIZE)  drives the BRAM port address.
REQ-016 bram_din  output  WIDTH  drives the BRAM port write data.
REQ-017 bram_dout  input  WIDTH  BRAM registered read-first output, valid 1 cycle after bram_en.

Function
REQ-018 bram_en SHALL equal fire; bram_we SHALL equal fire AND req_we.
REQ-019 bram_addr SHALL equal req_addr and bram_din SHALL equal req_wdata, combinationally.
REQ-020 A pending register (inflight, 1 bit, plus a want-response tag) SHALL be set in the cycle after a fire that expects a response, and cleared otherwise.
REQ-021 In the cycle with inflight=1, bram_dout SHALL be pushed into a 2-entry response FIFO.
REQ-022 resp_valid SHALL be high whenever the FIFO is non-empty; resp_rdata SHALL be the FIFO head.
REQ-023 A request fired in cycle N SHALL produce resp_valid no earlier than cycle N+2, given an empty FIFO.
REQ-024 Responses SHALL be returned in request order, with no loss or duplication.
REQ-025 req_ready SHALL be high when (occupancy + inflight) < 2, or when a pop occurs in the same cycle; this keeps full throughput of one request per cycle while resp_ready=1.
REQ-026 When the FIFO is full and there is no pop, req_ready SHALL be 0 and bram_en SHALL be 0.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 FIFO pointers SHALL wrap modulo 2.
REQ-029 Read data SHALL be read-first: a write to address A returns the old contents of A, if a response is produced.
REQ-030 Backpressure SHALL stall requests only; data already in the FIFO SHALL hold stable while resp_valid=1 and resp_ready=0.

Reset
REQ-031 While rst=1: req_ready=0, bram_en=0, bram_we=0, resp_valid=0, inflight=0, occupancy=0, and pointers=0.
REQ-032 A reset during operation SHALL discard the in-flight access and all FIFO contents; the BRAM data returned in the cycle after reset SHALL be ignored.
REQ-033 resp_rdata SHALL be don't-care while resp_valid=0.

Configuration
REQ-034 With macro HIR_BRAM_CTRL_WR_ACK_EN defined, every write SHALL produce a response carrying the read-first old data.
REQ-035 With HIR_BRAM_CTRL_WR_ACK_EN undefined, writes SHALL produce no response; they still consume one BRAM cycle but do not set inflight or push to the FIFO.

Verification
REQ-036 Scenario: reset, then read addr 5 (preloaded 0xA5) with resp_ready=1 -> resp_valid pulses 2 cycles after fire with rdata 0xA5.
REQ-037 Scenario: write 0x11 to addr 3 (old value 0x77), then read addr 3 -> with macro, responses 0x77 then 0x11; without macro, a single response 0x11.
REQ-038 Scenario: 8 back-to-back reads of addr 0..7 with resp_ready=1 -> req_ready stays 1 throughout and 8 in-order responses arrive on consecutive cycles.
REQ-039 Scenario: resp_ready=0, issue 4 reads -> 2 fire, then req_ready=0 and bram_en=0; head data stays stable; after resp_ready=1, all 4 responses arrive in order.
REQ-040 Scenario: assert rst for 1 cycle with inflight=1 and FIFO occupancy=1 -> next cycle resp_valid=0, no stale response ever appears, and a fresh read returns correct data.

Source files
------------

// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl: valid/ready request front-end for a single BRAM port with a
// registered read-first output, returning read data in request order through
// a 2-entry response FIFO.
//
// Build option: define HIR_BRAM_CTRL_WR_ACK_EN to make every write return a
// response carrying the old (read-first) contents of the written word.
// Without it, writes use one BRAM cycle but produce no response.
module bram_port_ctrl #(
    parameter int SIZE  = 1024,
    parameter int WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [$clog2(SIZE)-1:0] req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH-1:0]        resp_rdata,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [$clog2(SIZE)-1:0] bram_addr,
    output logic [WIDTH-1:0]        bram_din,
    input  logic [WIDTH-1:0]        bram_dout
);

    typedef logic [WIDTH-1:0] word_t;

    // Handshake and datapath-enable terms
    logic  fire;
    logic  pop;
    logic  push;
    logic  want_resp;

    // inflight_p1 marks that bram_dout carries data that must enter the FIFO;
    // it is only set for accesses that expect a response.
    logic  inflight_p1;

    // Response FIFO: two words, 1-bit pointers wrap naturally modulo 2
    word_t       fifo_mem [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;

    // Occupancy after one cycle of pushes and pops; push+pop cancels out.
    function automatic logic [1:0] occ_next(input logic [1:0] cur,
                                            input logic       do_push,
                                            input logic       do_pop);
        logic [1:0] nxt;
        nxt = cur;
        case ({do_push, do_pop})
            2'b10:   nxt = cur + 2'd1;
            2'b01:   nxt = cur - 2'd1;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Slots already committed: words in the FIFO plus the one in flight.
    function automatic logic has_room(input logic [1:0] cur_occ,
                                      input logic       cur_inflight);
        logic [2:0] committed;
        committed = {1'b0, cur_occ} + {2'b00, cur_inflight};
        return committed < 3'd2;
    endfunction

    // Decide which accesses return a response
    always_comb begin
        want_resp = 1'b1;
`ifdef HIR_BRAM_CTRL_WR_ACK_EN
        want_resp = 1'b1;
`else
        want_resp = ~req_we;
`endif
    end

    // Handshakes, BRAM port drive and FIFO head; outputs forced idle in reset
    always_comb begin
        resp_valid = 1'b0;
        pop        = 1'b0;
        req_ready  = 1'b0;
        fire       = 1'b0;
        push       = 1'b0;

        resp_valid = ~rst & (occ != 2'd0);
        pop        = resp_valid & resp_ready;
        // A same-cycle pop frees a slot, which keeps one request per cycle
        // flowing while the consumer is ready.
        req_ready  = ~rst & (has_room(occ, inflight_p1) | pop);
        fire       = req_valid & req_ready;
        push       = inflight_p1;

        bram_en    = fire;
        bram_we    = fire & req_we;
        bram_addr  = req_addr;
        bram_din   = req_wdata;
        resp_rdata = fifo_mem[rd_ptr];
    end

    // ---- stage p0 -> p1: BRAM access issued, response pending ----
    // Control state: in-flight flag, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_p1 <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            inflight_p1 <= fire & want_resp;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ_next(occ, push, pop);
        end
    end

    // ---- stage p1 -> FIFO: registered BRAM output captured ----
    // FIFO storage carries data only; reset clears the pointers instead
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bram_dout;
        end
    end

    // Flow control must never let the FIFO overflow or underflow
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && occ == 2'd2))
                else $error("response FIFO overflow");
            assert (!(pop && occ == 2'd0))
                else $error("response FIFO underflow");
        end
    end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Testbench for bram_port_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level reference.
module tb_bram_port_ctrl;

    localparam int SIZE  = 16;
    localparam int WIDTH = 32;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             bram_en;
    logic             bram_we;
    logic [AW-1:0]    bram_addr;
    logic [WIDTH-1:0] bram_din;
    logic [WIDTH-1:0] bram_dout;

    always #5 clk = ~clk;

    bram_port_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    function automatic logic [WIDTH-1:0] init_val(input int i);
        if (i == 3) return 32'h77;
        if (i == 5) return 32'hA5;
        return 32'h1000 + 32'(i) * 32'h0101;
    endfunction

    // BRAM with registered read-first output
    logic [WIDTH-1:0] bmem [0:SIZE-1];
    logic             loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < SIZE; i++) bmem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (bram_en) begin
            bram_dout <= bmem[bram_addr];
            if (bram_we) bmem[bram_addr] <= bram_din;
        end
    end

    // Reference: memory contents plus queue of owed responses with fire cycle
    typedef struct {
        logic [WIDTH-1:0] data;
        int               fcyc;
    } ent_t;
    ent_t             q[$];
    logic [WIDTH-1:0] ref_mem [0:SIZE-1];
    int               cyc   = 0;
    int               n_pop = 0;
    int               n_cmp = 0;
    int               n_fail = 0;
    logic             s_fire, s_pop, s_rst, s_we;
    logic [AW-1:0]    s_addr;
    logic [WIDTH-1:0] s_wd;

    function automatic logic want_resp(input logic we);
`ifdef HIR_BRAM_CTRL_WR_ACK_EN
        return 1'b1 | we;
`else
        return !we;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare every output against the reference (called at negedge)
    task automatic gen_check();
        logic ev, er;
        ev = 1'b0;
        if (!rst && q.size() > 0) ev = (q[0].fcyc + 2 <= cyc);
        er = !rst && (q.size() < 2 || (ev && resp_ready));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("bram_en", 32'(bram_en), 32'(req_valid && er));
        chk("bram_we", 32'(bram_we), 32'(req_valid && er && req_we));
        chk("bram_addr", 32'(bram_addr), 32'(req_addr));
        chk("bram_din", bram_din, req_wdata);
        if (ev) chk("resp_rdata", resp_rdata, q[0].data);
        s_fire = req_valid & req_ready;
        s_pop  = resp_valid & resp_ready;
        s_rst  = rst;
        s_we   = req_we;
        s_addr = req_addr;
        s_wd   = req_wdata;
    endtask

    task automatic apply(input logic r, input logic rv, input logic we,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] wd,
                         input logic rr);
        rst        = r;
        req_valid  = rv;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = rr;
        @(negedge clk);
        gen_check();
    endtask

    // Commit the cycle's transfers to the reference at the clock edge
    task automatic advance();
        logic [WIDTH-1:0] old;
        @(posedge clk);
        if (s_rst) begin
            q.delete();
        end else begin
            if (s_pop && q.size() > 0) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (s_fire) begin
                old = ref_mem[s_addr];
                if (s_we) ref_mem[s_addr] = s_wd;
                if (want_resp(s_we)) q.push_back('{old, cyc});
            end
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic             rv;
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wd;
        logic             rr;
        logic             x_ready;
        logic             x_en;
        logic             x_we;
        logic             x_valid;
        logic             chk_rd;
        logic [WIDTH-1:0] x_rdata;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int idx;
        int pops0;
        logic [WIDTH-1:0] e;

        // Cycle-by-cycle expectations: read of addr 5, then write/read of addr 3
        tbl[0] = '{1'b1, 1'b0, 4'd5, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5};
        tbl[3] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 4'd3, 32'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 4'd3, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
`ifdef HIR_BRAM_CTRL_WR_ACK_EN
        tbl[6] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h77};
`else
        tbl[6] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
`endif
        tbl[7] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11};
        tbl[8] = '{1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < SIZE; i++) ref_mem[i] = init_val(i);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, with a request offered that must not be accepted
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 4'd1, 32'h0, 1'b1);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_bram_en", 32'(bram_en), 32'd0);
            chk("rst_bram_we", 32'(bram_we), 32'd0);
            advance();
        end

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, tbl[i].rv, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rr);
            chk("tbl_req_ready", 32'(req_ready), 32'(tbl[i].x_ready));
            chk("tbl_bram_en", 32'(bram_en), 32'(tbl[i].x_en));
            chk("tbl_bram_we", 32'(bram_we), 32'(tbl[i].x_we));
            chk("tbl_resp_valid", 32'(resp_valid), 32'(tbl[i].x_valid));
            if (tbl[i].chk_rd) chk("tbl_resp_rdata", resp_rdata, tbl[i].x_rdata);
            advance();
        end

        // Eight back-to-back reads: full throughput, consecutive responses
        for (int c = 0; c < 11; c++) begin
            apply(1'b0, c < 8, 1'b0, 4'(c), 32'h0, 1'b1);
            if (c < 8) chk("burst_req_ready", 32'(req_ready), 32'd1);
            if (c >= 2 && c < 10) begin
                e = (c - 2 == 3) ? 32'h11 : init_val(c - 2);
                chk("burst_resp_valid", 32'(resp_valid), 32'd1);
                chk("burst_resp_rdata", resp_rdata, e);
            end else begin
                chk("burst_resp_idle", 32'(resp_valid), 32'd0);
            end
            advance();
        end

        // Backpressure: four reads with the consumer stalled, then released
        idx = 0;
        pops0 = n_pop;
        for (int c = 0; c < 14; c++) begin
            apply(1'b0, idx < 4, 1'b0, 4'(8 + idx), 32'h0, c >= 6);
            if (c >= 2 && c < 6) begin
                chk("stall_req_ready", 32'(req_ready), 32'd0);
                chk("stall_bram_en", 32'(bram_en), 32'd0);
            end
            if (c >= 3 && c < 6) chk("stall_head_hold", resp_rdata, init_val(8));
            if (req_valid && req_ready) idx++;
            advance();
        end
        chk("stall_fired", 32'(idx), 32'd4);
        chk("stall_pops", 32'(n_pop - pops0), 32'd4);

        // Reset while one response is buffered and one is in flight
        apply(1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 1'b0);
        advance();
        apply(1'b0, 1'b1, 1'b0, 4'd4, 32'h0, 1'b0);
        advance();
        apply(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        advance();
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
            chk("postrst_no_stale", 32'(resp_valid), 32'd0);
            advance();
        end
        apply(1'b0, 1'b1, 1'b0, 4'd6, 32'h0, 1'b1);
        advance();
        apply(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
        advance();
        apply(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
        chk("postrst_fresh_valid", 32'(resp_valid), 32'd1);
        chk("postrst_fresh_rdata", resp_rdata, init_val(6));
        advance();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            apply($urandom_range(0, 255) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 3,
                  4'($urandom_range(0, SIZE - 1)),
                  $urandom,
                  $urandom_range(0, 9) < 6);
            advance();
        end

        // Drain
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
            advance();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
